// File: rtl/vdcm_rc_pkg.sv
// Shared types and constants for the master QP rate controller.
// Holds default thresholds, the controller FSM state enum and the masterQp clamp helper.
package vdcm_rc_pkg;

   localparam int MQP_W = 7;

   localparam logic [MQP_W-1:0] MIN_MQP_DEF  = 7'd0;
   localparam logic [MQP_W-1:0] MAX_MQP_DEF  = 7'd72;
   localparam logic [MQP_W-1:0] INIT_MQP_DEF = 7'd32;

   localparam logic [11:0] DIFF_T1_DEF = 12'd8;
   localparam logic [11:0] DIFF_T2_DEF = 12'd32;
   localparam logic [11:0] DIFF_T3_DEF = 12'd96;

   localparam logic [15:0] FULL_LO_DEF = 16'd4096;
   localparam logic [15:0] FULL_HI_DEF = 16'd12288;

   typedef enum logic [1:0] {
      RC_IDLE   = 2'd0,
      RC_DIFF   = 2'd1,
      RC_DELTA  = 2'd2,
      RC_UPDATE = 2'd3
   } rc_state_e;

   // Saturate a signed 9-bit candidate QP into the legal [lo, hi] window.
   function automatic logic [MQP_W-1:0] clamp_mqp(
      input logic signed [8:0]  q,
      input logic [MQP_W-1:0]   lo,
      input logic [MQP_W-1:0]   hi
   );
      logic signed [8:0] loS;
      logic signed [8:0] hiS;
      loS = $signed({2'b00, lo});
      hiS = $signed({2'b00, hi});
      if (q < loS) begin
         return lo;
      end else if (q > hiS) begin
         return hi;
      end else begin
         return q[MQP_W-1:0];
      end
   endfunction

endpackage

// File: rtl/qp_delta_lut.sv
// Maps |bits - target| and its sign to a bounded signed QP step (0/1/2/4),
// with the step direction gated by the captured rate-buffer fullness.
module qp_delta_lut
   import vdcm_rc_pkg::*;
#(
   parameter logic [11:0] DIFF_T1 = DIFF_T1_DEF,
   parameter logic [11:0] DIFF_T2 = DIFF_T2_DEF,
   parameter logic [11:0] DIFF_T3 = DIFF_T3_DEF,
   parameter logic [15:0] FULL_LO = FULL_LO_DEF,
   parameter logic [15:0] FULL_HI = FULL_HI_DEF
) (
   input  logic [11:0]       i_absDiff,
   input  logic              i_diffNeg,
   input  logic [15:0]       i_fullness,
   output logic signed [3:0] o_delta
);

   logic [2:0] w_mag;
   logic [3:0] w_magExt;

   // A nearly full buffer must not lower QP further, a nearly empty one must not raise it.
   always_comb begin
      w_mag = 3'd0;
      if (i_absDiff <= DIFF_T1) begin
         w_mag = 3'd0;
      end else if (i_absDiff <= DIFF_T2) begin
         w_mag = 3'd1;
      end else if (i_absDiff <= DIFF_T3) begin
         w_mag = 3'd2;
      end else begin
         w_mag = 3'd4;
      end
      if (i_diffNeg && (i_fullness >= FULL_HI)) begin
         w_mag = 3'd0;
      end
      if (!i_diffNeg && (i_fullness <= FULL_LO)) begin
         w_mag = 3'd0;
      end
   end

   assign w_magExt = {1'b0, w_mag};
   assign o_delta  = i_diffNeg ? -$signed(w_magExt) : $signed(w_magExt);

endmodule

// File: rtl/master_qp_rate_ctrl.sv
// Encoder rate controller: one masterQp update per accepted block, 3-cycle latency.
// Optional MASTER_QP_PANIC_EN forces MAX_MQP when captured fullness reaches FULL_PANIC.
module master_qp_rate_ctrl
   import vdcm_rc_pkg::*;
#(
`ifdef MASTER_QP_PANIC_EN
   parameter logic [15:0]      FULL_PANIC = 16'd15360,
`endif
   parameter logic [MQP_W-1:0] MIN_MQP    = MIN_MQP_DEF,
   parameter logic [MQP_W-1:0] MAX_MQP    = MAX_MQP_DEF,
   parameter logic [MQP_W-1:0] INIT_MQP   = INIT_MQP_DEF,
   parameter logic [11:0]      DIFF_T1    = DIFF_T1_DEF,
   parameter logic [11:0]      DIFF_T2    = DIFF_T2_DEF,
   parameter logic [11:0]      DIFF_T3    = DIFF_T3_DEF,
   parameter logic [15:0]      FULL_LO    = FULL_LO_DEF,
   parameter logic [15:0]      FULL_HI    = FULL_HI_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             slice_start,
   input  logic [6:0]       init_qp,
   input  logic [11:0]      block_bits,
   input  logic [11:0]      target_bits,
   input  logic [15:0]      buffer_fullness,
   input  logic             block_bits_valid,
   output logic             in_ready,
   output logic [MQP_W-1:0] masterQp,
   output logic             masterQp_valid
);

   rc_state_e r_state;
   rc_state_e w_stateNext;

   logic [11:0]       r_blockBits;
   logic [11:0]       r_targetBits;
   logic [15:0]       r_fullness;
   logic              r_diffNeg;
   logic [11:0]       r_absDiff;
   logic signed [3:0] r_delta;
   logic [MQP_W-1:0]  r_masterQp;
   logic              r_qpValid;
`ifdef MASTER_QP_PANIC_EN
   logic              r_panic;
`endif

   logic              w_accept;
   logic signed [12:0] w_diff;
   logic signed [12:0] w_diffNegated;
   logic [11:0]       w_absDiff;
   logic signed [3:0] w_lutDelta;
   logic signed [8:0] w_qSum;

   assign in_ready       = (r_state == RC_IDLE);
   assign w_accept       = block_bits_valid & in_ready & ~slice_start;
   assign masterQp       = r_masterQp;
   assign masterQp_valid = r_qpValid;

   assign w_diff        = $signed({1'b0, r_blockBits}) - $signed({1'b0, r_targetBits});
   assign w_diffNegated = -w_diff;
   assign w_absDiff     = w_diff[12] ? w_diffNegated[11:0] : w_diff[11:0];
   assign w_qSum        = $signed({2'b00, r_masterQp}) + $signed({{5{r_delta[3]}}, r_delta});

   qp_delta_lut #(
      .DIFF_T1 (DIFF_T1),
      .DIFF_T2 (DIFF_T2),
      .DIFF_T3 (DIFF_T3),
      .FULL_LO (FULL_LO),
      .FULL_HI (FULL_HI)
   ) u_deltaLut (
      .i_absDiff  (r_absDiff),
      .i_diffNeg  (r_diffNeg),
      .i_fullness (r_fullness),
      .o_delta    (w_lutDelta)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RC_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // slice_start abandons whatever block is in flight and returns to IDLE.
   always_comb begin
      w_stateNext = r_state;
      if (slice_start) begin
         w_stateNext = RC_IDLE;
      end else begin
         unique case (r_state)
            RC_IDLE:   if (w_accept) w_stateNext = RC_DIFF;
            RC_DIFF:   w_stateNext = RC_DELTA;
            RC_DELTA:  w_stateNext = RC_UPDATE;
            RC_UPDATE: w_stateNext = RC_IDLE;
            default:   w_stateNext = RC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blockBits  <= '0;
         r_targetBits <= '0;
         r_fullness   <= '0;
         r_diffNeg    <= 1'b0;
         r_absDiff    <= '0;
         r_delta      <= '0;
         r_masterQp   <= INIT_MQP;
         r_qpValid    <= 1'b0;
`ifdef MASTER_QP_PANIC_EN
         r_panic      <= 1'b0;
`endif
      end else begin
         r_qpValid <= 1'b0;
         if (slice_start) begin
            r_masterQp <= clamp_mqp($signed({2'b00, init_qp}), MIN_MQP, MAX_MQP);
            r_qpValid  <= 1'b1;
         end else begin
            unique case (r_state)
               RC_IDLE: begin
                  if (w_accept) begin
                     r_blockBits  <= block_bits;
                     r_targetBits <= target_bits;
                     r_fullness   <= buffer_fullness;
                  end
               end
               RC_DIFF: begin
                  r_diffNeg <= w_diff[12];
                  r_absDiff <= w_absDiff;
               end
               RC_DELTA: begin
                  r_delta <= w_lutDelta;
`ifdef MASTER_QP_PANIC_EN
                  r_panic <= (r_fullness >= FULL_PANIC);
`endif
               end
               RC_UPDATE: begin
`ifdef MASTER_QP_PANIC_EN
                  r_masterQp <= r_panic ? MAX_MQP : clamp_mqp(w_qSum, MIN_MQP, MAX_MQP);
`else
                  r_masterQp <= clamp_mqp(w_qSum, MIN_MQP, MAX_MQP);
`endif
                  r_qpValid  <= 1'b1;
               end
               default: begin
                  r_qpValid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_master_qp_rate_ctrl.sv
// Self-checking bench for master_qp_rate_ctrl: directed literal cases plus a
// randomized run compared every cycle against a transaction-level reference model.
module tb_master_qp_rate_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        slice_start = 1'b0;
   logic [6:0]  init_qp = '0;
   logic [11:0] block_bits = '0;
   logic [11:0] target_bits = '0;
   logic [15:0] buffer_fullness = '0;
   logic        block_bits_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  masterQp;
   logic        masterQp_valid;

   int errorCount = 0;
   int checkCount = 0;

   // Reference model: current QP, pending result and cycles left until it lands.
   int mQp = 32;
   int mValid = 0;
   int mBusy = 0;
   int mPending = 0;

   int offs[11] = '{0, 7, 8, 9, 31, 32, 33, 95, 96, 97, 500};
   int fulls[10] = '{4095, 4096, 4097, 12287, 12288, 12289, 15359, 15360, 15361, 8000};

   master_qp_rate_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .slice_start      (slice_start),
      .init_qp          (init_qp),
      .block_bits       (block_bits),
      .target_bits      (target_bits),
      .buffer_fullness  (buffer_fullness),
      .block_bits_valid (block_bits_valid),
      .in_ready         (in_ready),
      .masterQp         (masterQp),
      .masterQp_valid   (masterQp_valid)
   );

   always #5 clk = ~clk;

   function automatic int clampQp(input int q);
      if (q < 0) return 0;
      if (q > 72) return 72;
      return q;
   endfunction

   function automatic int refNextQp(input int cur, input int bits, input int tgt, input int full);
      int diff;
      int a;
      int mag;
      diff = bits - tgt;
      a = (diff < 0) ? -diff : diff;
`ifdef MASTER_QP_PANIC_EN
      if (full >= 15360) return 72;
`endif
      if (a <= 8) mag = 0;
      else if (a <= 32) mag = 1;
      else if (a <= 96) mag = 2;
      else mag = 4;
      if (diff < 0 && full >= 12288) mag = 0;
      if (diff > 0 && full <= 4096) mag = 0;
      return clampQp((diff < 0) ? cur - mag : cur + mag);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mQp = 32;
         mValid = 0;
         mBusy = 0;
      end else begin
         mValid = 0;
         if (slice_start) begin
            mQp = clampQp(int'(init_qp));
            mValid = 1;
            mBusy = 0;
         end else if (mBusy > 0) begin
            mBusy--;
            if (mBusy == 0) begin
               mQp = mPending;
               mValid = 1;
            end
         end else if (block_bits_valid) begin
            mPending = refNextQp(mQp, int'(block_bits), int'(target_bits), int'(buffer_fullness));
            mBusy = 3;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("in_ready", int'(in_ready), int'(mBusy == 0));
         checkOutput("masterQp", int'(masterQp), mQp);
         checkOutput("masterQp_valid", int'(masterQp_valid), mValid);
      end
   end

   // Presents one block from IDLE and returns on the negedge where the result is visible.
   task automatic applyStimulus(input int bits, input int tgt, input int full);
      @(negedge clk);
      block_bits = 12'(bits);
      target_bits = 12'(tgt);
      buffer_fullness = 16'(full);
      block_bits_valid = 1'b1;
      @(negedge clk);
      block_bits_valid = 1'b0;
      checkOutput("busy in_ready", int'(in_ready), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic startSlice(input int qp);
      @(negedge clk);
      slice_start = 1'b1;
      init_qp = 7'(qp);
      @(negedge clk);
      slice_start = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("reset masterQp", int'(masterQp), 32);
      checkOutput("reset valid", int'(masterQp_valid), 0);
      checkOutput("reset in_ready", int'(in_ready), 1);

      applyStimulus(100, 100, 8000);
      checkOutput("equal bits qp", int'(masterQp), 32);
      checkOutput("equal bits valid", int'(masterQp_valid), 1);
      @(negedge clk);
      checkOutput("valid one cycle", int'(masterQp_valid), 0);

      applyStimulus(200, 100, 8000);
      checkOutput("diff +100 qp", int'(masterQp), 36);

      startSlice(71);
      checkOutput("slice 71 qp", int'(masterQp), 71);
      applyStimulus(600, 100, 8000);
      checkOutput("clamp high", int'(masterQp), 72);

      startSlice(1);
      applyStimulus(100, 600, 8000);
      checkOutput("clamp low", int'(masterQp), 0);

      startSlice(40);
      applyStimulus(60, 100, 13000);
      checkOutput("full hi gate", int'(masterQp), 40);
      applyStimulus(140, 100, 2000);
      checkOutput("full lo gate", int'(masterQp), 40);

      // Fullness 16000 is above FULL_HI too, so without panic the decrease is suppressed.
      applyStimulus(100, 600, 16000);
`ifdef MASTER_QP_PANIC_EN
      checkOutput("panic qp", int'(masterQp), 72);
`else
      checkOutput("panic qp", int'(masterQp), 40);
`endif

      @(negedge clk);
      block_bits = 12'd200;
      target_bits = 12'd100;
      buffer_fullness = 16'd8000;
      block_bits_valid = 1'b1;
      @(negedge clk);
      block_bits_valid = 1'b0;
      @(negedge clk);
      slice_start = 1'b1;
      init_qp = 7'd90;
      @(negedge clk);
      slice_start = 1'b0;
      checkOutput("abort qp", int'(masterQp), 72);
      checkOutput("abort valid", int'(masterQp_valid), 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("no late pulse", int'(masterQp_valid), 0);
      end

      @(negedge clk);
      slice_start = 1'b1;
      init_qp = 7'd20;
      block_bits = 12'd600;
      target_bits = 12'd100;
      block_bits_valid = 1'b1;
      @(negedge clk);
      slice_start = 1'b0;
      block_bits_valid = 1'b0;
      checkOutput("simul slice qp", int'(masterQp), 20);
      checkOutput("simul dropped", int'(in_ready), 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("simul no pulse", int'(masterQp_valid), 0);
      end

      for (int i = 0; i < 800; i++) begin
         int r;
         int tgt;
         int off;
         @(negedge clk);
         r = int'($urandom_range(0, 199));
         if (r == 199) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         slice_start = (r < 6);
         init_qp = 7'($urandom_range(0, 127));
         block_bits_valid = ($urandom_range(0, 3) != 0);
         tgt = int'($urandom_range(600, 3400));
         off = offs[$urandom_range(0, 10)];
         if ($urandom_range(0, 1) == 1) off = -off;
         target_bits = 12'(tgt);
         block_bits = 12'(tgt + off);
         if ($urandom_range(0, 1) == 1)
            buffer_fullness = 16'(fulls[$urandom_range(0, 9)]);
         else
            buffer_fullness = 16'($urandom_range(0, 65535));
      end
      slice_start = 1'b0;
      block_bits_valid = 1'b0;
      repeat (6) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
